font_rom_arbiter: RTL and testbench
===================================

# font_rom_arbiter

Shares the single character font ROM (12-bit address, 8-bit data) between two requesters, e.g. the key-driven character writer and the HDMI overlay glyph renderer. It grants at most one ROM read per cycle and drives the ROM address. It tracks every in-flight read and steers returning ROM data to the requester that issued it. A lock input lets a requester hold the ROM for a whole glyph-row burst, bounded by a starvation limit.

## Interface
Parameters:
- ROM_LATENCY, 1: cycles from `romAddress` register output to valid `romData` (1 = ROM registers its address).
- MAX_LOCK, 16: maximum consecutive grants to a locked owner while the other requester is waiting; range 1..255.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  read request from requester 0 / 1.
- addr0 / addr1  in  12  ROM address for the request.
- lock0 / lock1  in  1  keep ownership after this grant.
- gnt0 / gnt1  out  1  combinational; address accepted this cycle.
- rvalid0 / rvalid1  out  1  registered; `rdataN` valid this cycle.
- rdata0 / rdata1  out  8  `romData` pass-through; meaningful only with `rvalidN`.
- romAddress  out  12  registered address to the ROM.
- romData  in  8  ROM read data.

## Operation
- States:
  - IDLE: no owner.
  - OWN0 / OWN1: locked owner.
- Grant rules:
  - At most one `gnt` per cycle.
  - `gntN` is asserted only while `reqN` is high.
  - A request holds its address stable until granted.
- IDLE arbitration:
  - One requester active → it is granted.
  - Both active → round-robin, so the requester not granted last wins (see Configuration).
  - `rr_last` resets to 1, so requester 0 wins the first tie.
- Granted with `lockN`=1 → next state OWNN and lock counter = 1.
- OWNN behaviour:
  - Only N is granted; the other requester is stalled.
  - Counter increments per grant to N while the other requester is requesting.
  - Counter holds while the other requester is idle.
- Leave OWNN → IDLE when any of these holds:
  - `reqN`=0.
  - A grant occurs with `lockN`=0.
  - Counter reaches MAX_LOCK with the other requester requesting.
- On the MAX_LOCK release cycle the owner gets no grant; the other requester is granted that cycle.
- On every grant:
  - `romAddress` <= granted address.
  - A tag {valid, id} enters a shift register of depth 1+ROM_LATENCY.
- When idle, `romAddress` holds its last value.
- Tag at the output stage drives `rvalid0`/`rvalid1`; `rdataN` = `romData`.
- Back-to-back grants produce back-to-back `rvalid`, one per cycle, in issue order.

## Timing
- Grant in cycle N → `romAddress` updated at the N/N+1 edge → `rvalidX` high in cycle N+1+ROM_LATENCY (N+2 by default).
- Throughput: one read per cycle; no bubbles between alternating requesters.
- Reset values: state IDLE, `romAddress`=0, all tags cleared, `rvalid0`=`rvalid1`=0, `gnt0`=`gnt1`=0 during reset, `rr_last`=1, lock counter 0.
- Reset mid-operation: in-flight reads are discarded, and no `rvalid` asserts in the cycles after reset deasserts for reads issued before reset.
- A request whose `req` and `lock` drop in the same cycle it would be granted is not granted, and the state returns to IDLE.
- Simultaneous request with the owner's lock release: the release grant goes to the owner; the other requester wins the next cycle by round-robin.
- Counter width is 8 bits and never wraps (saturates at MAX_LOCK).

## Configuration
- Macro `FONT_ROM_ARB_ROUND_ROBIN_EN`.
- Defined: IDLE ties use round-robin via `rr_last`.
- Undefined:
  - Fixed priority; requester 0 always wins IDLE ties.
  - `rr_last` is not implemented.
  - Lock and MAX_LOCK behaviour is unchanged.

## Test plan
- Single requester: `req0`=1, `addr0`=0x041 in cycle 3 → `gnt0` in cycle 3, `romAddress`=0x041 in cycle 4, `rvalid0` in cycle 5 carrying ROM byte at 0x041; `rvalid1` never asserted.
- Contention: `req0`=`req1`=1 for 4 cycles with no lock → grants alternate 0,1,0,1 (fixed priority build: 0,0,0,0), and `rvalid` ids follow the same order 2 cycles later.
- Lock burst: `req0`+`lock0` for 16 rows (addresses 0x410..0x41F) with `req1` idle → 16 consecutive `gnt0`; `req1` asserted mid-burst is stalled until `lock0` drops.
- Starvation: MAX_LOCK=4, `req0`+`lock0` held, `req1` held → `gnt0` ×4, then `gnt1`, then `req0` regains ownership.
- Reset mid-flight: grant at cycle 10, `reset` high in cycle 11 → no `rvalid` at cycle 12, `romAddress`=0, state IDLE.
- Latency parameter: ROM_LATENCY=2 → `rvalid` 3 cycles after grant, and data is steered correctly under alternating grants.

Source files
------------

// File: rtl/font_rom_arbiter.sv
// Two-requester arbiter for the shared 4K x 8 font ROM: one read per cycle, lockable bursts
// bounded by MAX_LOCK, read data steered back by id. Build macro FONT_ROM_ARB_ROUND_ROBIN_EN.
module font_rom_arbiter #(
  parameter int ROM_LATENCY = 1,
  parameter int MAX_LOCK    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [11:0] addr0,
  input  logic [11:0] addr1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic [11:0] romAddress,
  input  logic [7:0]  romData,
  output logic [1:0]  state_dbg
);

  // Handshake: reqN/addrN/lockN form a request that transfers in any cycle where
  // reqN && gntN are both high; the requester holds addrN stable until then. Read data
  // has no back-pressure: rdataN is meaningful exactly in the cycles rvalidN is high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  state_t               state_q, state_nxt;
  logic [7:0]           lock_cnt_q, lock_cnt_nxt;
  logic                 gnt0_c, gnt1_c;
  logic                 tie_to_0;
  logic [ROM_LATENCY:0] tag_v_q;
  logic [ROM_LATENCY:0] tag_id_q;

`ifdef FONT_ROM_ARB_ROUND_ROBIN_EN
  // rr_last_q holds the id granted most recently; the other requester wins the next tie.
  logic rr_last_q;
  assign tie_to_0 = rr_last_q;

  always_ff @(posedge clock) begin
    if (reset)       rr_last_q <= 1'b1;
    else if (gnt0_c) rr_last_q <= 1'b0;
    else if (gnt1_c) rr_last_q <= 1'b1;
  end
`else
  assign tie_to_0 = 1'b1;
`endif

  always_comb begin
    state_nxt    = state_q;
    lock_cnt_nxt = lock_cnt_q;
    gnt0_c       = 1'b0;
    gnt1_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || tie_to_0)) gnt0_c = 1'b1;
        else if (req1)                   gnt1_c = 1'b1;
      end
      OWN0: begin
        if (!req0) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = 8'd0;
        end else if (req1 && lock_cnt_q >= MAX_LOCK_C) begin
          gnt1_c = 1'b1;
        end else begin
          gnt0_c = 1'b1;
        end
      end
      OWN1: begin
        if (!req1) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = 8'd0;
        end else if (req0 && lock_cnt_q >= MAX_LOCK_C) begin
          gnt0_c = 1'b1;
        end else begin
          gnt1_c = 1'b1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = 8'd0;
      end
    endcase

    // Ownership after a grant: a continuing owner only counts grants that stall the other side.
    if (gnt0_c) begin
      if (!lock0) begin
        state_nxt    = IDLE;
        lock_cnt_nxt = 8'd0;
      end else if (state_q == OWN0) begin
        if (req1 && lock_cnt_q < MAX_LOCK_C) lock_cnt_nxt = lock_cnt_q + 8'd1;
      end else begin
        state_nxt    = OWN0;
        lock_cnt_nxt = 8'd1;
      end
    end

    if (gnt1_c) begin
      if (!lock1) begin
        state_nxt    = IDLE;
        lock_cnt_nxt = 8'd0;
      end else if (state_q == OWN1) begin
        if (req0 && lock_cnt_q < MAX_LOCK_C) lock_cnt_nxt = lock_cnt_q + 8'd1;
      end else begin
        state_nxt    = OWN1;
        lock_cnt_nxt = 8'd1;
      end
    end
  end

  assign gnt0      = gnt0_c & ~reset;
  assign gnt1      = gnt1_c & ~reset;
  assign state_dbg = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      lock_cnt_q <= 8'd0;
      romAddress <= 12'h000;
    end else begin
      state_q    <= state_nxt;
      lock_cnt_q <= lock_cnt_nxt;
      if (gnt0_c)      romAddress <= addr0;
      else if (gnt1_c) romAddress <= addr1;
    end
  end

  // Tag pipeline: stage 0 lines up with romAddress, the last stage with romData.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      tag_v_q[0]  <= gnt0_c | gnt1_c;
      tag_id_q[0] <= gnt1_c;
      for (int i = 1; i <= ROM_LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  assign rvalid0 = tag_v_q[ROM_LATENCY] & ~tag_id_q[ROM_LATENCY];
  assign rvalid1 = tag_v_q[ROM_LATENCY] &  tag_id_q[ROM_LATENCY];
  assign rdata0  = romData;
  assign rdata1  = romData;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: two instances (latency 1 / MAX_LOCK 16 and latency 2 / MAX_LOCK 4)
// share one stimulus stream and are checked cycle by cycle against a behavioural model.
`timescale 1ns/1ps
module tb_font_rom_arbiter;

  localparam int LAT_A = 1;
  localparam int ML_A  = 16;
  localparam int LAT_B = 2;
  localparam int ML_B  = 4;
`ifdef FONT_ROM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset / DUTs ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, lock0, lock1;
  logic [11:0] addr0, addr1;

  logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a;
  logic [7:0]  rdata0_a, rdata1_a, rom_data_a;
  logic [11:0] rom_addr_a;
  logic [1:0]  state_a;
  logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b;
  logic [7:0]  rdata0_b, rdata1_b, rom_data_b;
  logic [11:0] rom_addr_b;
  logic [1:0]  state_b;

  always #5 clock = ~clock;

  font_rom_arbiter #(.ROM_LATENCY(LAT_A), .MAX_LOCK(ML_A)) dut_a (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0_a), .gnt1(gnt1_a),
    .rvalid0(rvalid0_a), .rvalid1(rvalid1_a), .rdata0(rdata0_a), .rdata1(rdata1_a),
    .romAddress(rom_addr_a), .romData(rom_data_a), .state_dbg(state_a)
  );

  font_rom_arbiter #(.ROM_LATENCY(LAT_B), .MAX_LOCK(ML_B)) dut_b (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0_b), .gnt1(gnt1_b),
    .rvalid0(rvalid0_b), .rvalid1(rvalid1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
    .romAddress(rom_addr_b), .romData(rom_data_b), .state_dbg(state_b)
  );

  function automatic logic [7:0] rom_byte(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h5a;
  endfunction

  // ROM models: address registered inside the ROM, plus one extra stage for instance b.
  logic [7:0] rom_pipe_a, rom_pipe_b1, rom_pipe_b2;
  always @(posedge clock) begin
    rom_pipe_a  <= rom_byte(rom_addr_a);
    rom_pipe_b1 <= rom_byte(rom_addr_b);
    rom_pipe_b2 <= rom_pipe_b1;
  end
  assign rom_data_a = rom_pipe_a;
  assign rom_data_b = rom_pipe_b2;

  logic [1:0]  got_gnt [2];
  logic [1:0]  got_rv  [2];
  logic [15:0] got_rd  [2];
  logic [11:0] got_ra  [2];
  logic [1:0]  got_st  [2];
  assign got_gnt[0] = {gnt1_a, gnt0_a};
  assign got_gnt[1] = {gnt1_b, gnt0_b};
  assign got_rv[0]  = {rvalid1_a, rvalid0_a};
  assign got_rv[1]  = {rvalid1_b, rvalid0_b};
  assign got_rd[0]  = {rdata1_a, rdata0_a};
  assign got_rd[1]  = {rdata1_b, rdata0_b};
  assign got_ra[0]  = rom_addr_a;
  assign got_ra[1]  = rom_addr_b;
  assign got_st[0]  = state_a;
  assign got_st[1]  = state_b;

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [19:0] due;
    logic        id;
    logic [11:0] addr;
  } rd_t;

  rd_t         exp_q0[$];
  rd_t         exp_q1[$];
  int          owner  [2];
  int          streak [2];
  int          last_g [2];
  logic [11:0] mdl_ra [2];
  int          cyc;
  logic [1:0]  exp_gnt[2];
  logic [1:0]  exp_rv [2];
  logic [7:0]  exp_rd [2];
  logic [11:0] exp_ra [2];
  int          checks;
  int          errors;

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic int ml_of(input int k);
    return (k == 0) ? ML_A : ML_B;
  endfunction

  // Driver: applies one cycle of inputs, then works out what each instance must show this cycle.
  task automatic drive(input logic rst, input logic r0, input logic [11:0] a0, input logic l0,
                       input logic r1, input logic [11:0] a1, input logic l1);
    logic [1:0]  rq, lk;
    logic [11:0] ad [2];
    int          g, o;
    rd_t         e;
    rd_t         q[$];
    @(negedge clock);
    cyc++;
    reset = rst; req0 = r0; addr0 = a0; lock0 = l0; req1 = r1; addr1 = a1; lock1 = l1;
    #1;
    rq = {r1, r0};
    lk = {l1, l0};
    ad[0] = a0;
    ad[1] = a1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) q = exp_q0; else q = exp_q1;
      exp_rv[k] = 2'b00;
      exp_rd[k] = 8'h00;
      if (q.size() > 0 && q[0].due == 20'(cyc)) begin
        e = q.pop_front();
        exp_rv[k] = e.id ? 2'b10 : 2'b01;
        exp_rd[k] = rom_byte(e.addr);
      end
      exp_ra[k] = mdl_ra[k];
      g = -1;
      if (rst) begin
        q.delete();
        owner[k]  = -1;
        streak[k] = 0;
        last_g[k] = 1;
        mdl_ra[k] = 12'h000;
      end else begin
        if (owner[k] < 0) begin
          if (rq == 2'b11)  g = (RR && last_g[k] == 0) ? 1 : 0;
          else if (rq[0])   g = 0;
          else if (rq[1])   g = 1;
        end else begin
          o = owner[k];
          if (!rq[o])                                      owner[k] = -1;
          else if (rq[1-o] && streak[k] >= ml_of(k))      g = 1 - o;
          else                                             g = o;
        end
        if (g >= 0) begin
          e.due  = 20'(cyc + 1 + lat_of(k));
          e.id   = (g == 1);
          e.addr = ad[g];
          q.push_back(e);
          mdl_ra[k] = ad[g];
          last_g[k] = g;
          if (!lk[g]) owner[k] = -1;
          else if (owner[k] == g) begin
            if (rq[1-g] && streak[k] < ml_of(k)) streak[k]++;
          end else begin
            owner[k]  = g;
            streak[k] = 1;
          end
        end
        if (owner[k] < 0) streak[k] = 0;
      end
      exp_gnt[k] = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
      if (k == 0) exp_q0 = q; else exp_q1 = q;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [7:0] obs_rd;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 12'h123, 1'b1, 1'b1, 12'h456, 1'b0);
      for (int k = 0; k < 2; k++) begin
        obs_rd = exp_rv[k][1] ? got_rd[k][15:8] : got_rd[k][7:0];
        checks++;
        if (got_gnt[k] !== 2'b00) begin errors++; $display("FAIL reset_gnt dut%0d cyc %0d got %b exp 00", k, cyc, got_gnt[k]); end
        checks++;
        if (got_rv[k] !== exp_rv[k]) begin errors++; $display("FAIL reset_rvalid dut%0d cyc %0d got %b exp %b", k, cyc, got_rv[k], exp_rv[k]); end
        checks++;
        if (got_ra[k] !== 12'h000) begin errors++; $display("FAIL reset_romaddr dut%0d cyc %0d got %h exp 000", k, cyc, got_ra[k]); end
        checks++;
        if (got_st[k] !== 2'd0) begin errors++; $display("FAIL reset_state dut%0d cyc %0d got %0d exp 0", k, cyc, got_st[k]); end
        if (exp_rv[k] != 2'b00) begin
          checks++;
          if (obs_rd !== exp_rd[k]) begin errors++; $display("FAIL reset_rdata dut%0d cyc %0d got %h exp %h", k, cyc, obs_rd, exp_rd[k]); end
        end
      end
    end
  endtask

  task automatic test_single;
    logic [7:0] obs_rd;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, (i == 2), 12'h041, 1'b0, 1'b0, 12'h7ff, 1'b0);
      for (int k = 0; k < 2; k++) begin
        obs_rd = exp_rv[k][1] ? got_rd[k][15:8] : got_rd[k][7:0];
        checks++;
        if (got_gnt[k] !== exp_gnt[k]) begin errors++; $display("FAIL single_gnt dut%0d cyc %0d got %b exp %b", k, cyc, got_gnt[k], exp_gnt[k]); end
        checks++;
        if (got_rv[k] !== exp_rv[k]) begin errors++; $display("FAIL single_rvalid dut%0d cyc %0d got %b exp %b", k, cyc, got_rv[k], exp_rv[k]); end
        checks++;
        if (got_ra[k] !== exp_ra[k]) begin errors++; $display("FAIL single_romaddr dut%0d cyc %0d got %h exp %h", k, cyc, got_ra[k], exp_ra[k]); end
        if (exp_rv[k] != 2'b00) begin
          checks++;
          if (obs_rd !== exp_rd[k]) begin errors++; $display("FAIL single_rdata dut%0d cyc %0d got %h exp %h", k, cyc, obs_rd, exp_rd[k]); end
        end
      end
    end
  endtask

  task automatic test_contention;
    logic [7:0] obs_rd;
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, (i < 4), 12'($urandom_range(0, 4095)), 1'b0,
                  (i < 4), 12'($urandom_range(0, 4095)), 1'b0);
      for (int k = 0; k < 2; k++) begin
        obs_rd = exp_rv[k][1] ? got_rd[k][15:8] : got_rd[k][7:0];
        checks++;
        if (got_gnt[k] !== exp_gnt[k]) begin errors++; $display("FAIL contention_gnt dut%0d cyc %0d got %b exp %b", k, cyc, got_gnt[k], exp_gnt[k]); end
        checks++;
        if (got_rv[k] !== exp_rv[k]) begin errors++; $display("FAIL contention_rvalid dut%0d cyc %0d got %b exp %b", k, cyc, got_rv[k], exp_rv[k]); end
        checks++;
        if (got_ra[k] !== exp_ra[k]) begin errors++; $display("FAIL contention_romaddr dut%0d cyc %0d got %h exp %h", k, cyc, got_ra[k], exp_ra[k]); end
        if (exp_rv[k] != 2'b00) begin
          checks++;
          if (obs_rd !== exp_rd[k]) begin errors++; $display("FAIL contention_rdata dut%0d cyc %0d got %h exp %h", k, cyc, obs_rd, exp_rd[k]); end
        end
      end
    end
  endtask

  task automatic test_lock_burst;
    logic [7:0] obs_rd;
    for (int i = 0; i < 21; i++) begin
      drive(1'b0, (i < 16), 12'h410 + 12'(i), (i < 15),
                  (i >= 8 && i < 17), 12'h3c0 + 12'(i), 1'b0);
      for (int k = 0; k < 2; k++) begin
        obs_rd = exp_rv[k][1] ? got_rd[k][15:8] : got_rd[k][7:0];
        checks++;
        if (got_gnt[k] !== exp_gnt[k]) begin errors++; $display("FAIL lock_gnt dut%0d cyc %0d got %b exp %b", k, cyc, got_gnt[k], exp_gnt[k]); end
        checks++;
        if (got_rv[k] !== exp_rv[k]) begin errors++; $display("FAIL lock_rvalid dut%0d cyc %0d got %b exp %b", k, cyc, got_rv[k], exp_rv[k]); end
        checks++;
        if (got_ra[k] !== exp_ra[k]) begin errors++; $display("FAIL lock_romaddr dut%0d cyc %0d got %h exp %h", k, cyc, got_ra[k], exp_ra[k]); end
        if (exp_rv[k] != 2'b00) begin
          checks++;
          if (obs_rd !== exp_rd[k]) begin errors++; $display("FAIL lock_rdata dut%0d cyc %0d got %h exp %h", k, cyc, obs_rd, exp_rd[k]); end
        end
      end
    end
  endtask

  task automatic test_starvation;
    logic [7:0] obs_rd;
    logic [1:0] want_b [6];
    int         n0_a;
    want_b = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    n0_a = 0;
    for (int i = 0; i < 14; i++) begin
      drive((i == 0), 1'b1, 12'($urandom_range(0, 4095)), 1'b1,
                      1'b1, 12'($urandom_range(0, 4095)), 1'b0);
      if (i >= 1 && i <= 6) begin
        checks++;
        if (got_gnt[1] !== want_b[i-1]) begin errors++; $display("FAIL starve_seq step %0d got %b exp %b", i - 1, got_gnt[1], want_b[i-1]); end
      end
      if (gnt0_a === 1'b1) n0_a++;
      for (int k = 0; k < 2; k++) begin
        obs_rd = exp_rv[k][1] ? got_rd[k][15:8] : got_rd[k][7:0];
        checks++;
        if (got_gnt[k] !== exp_gnt[k]) begin errors++; $display("FAIL starve_gnt dut%0d cyc %0d got %b exp %b", k, cyc, got_gnt[k], exp_gnt[k]); end
        checks++;
        if (got_rv[k] !== exp_rv[k]) begin errors++; $display("FAIL starve_rvalid dut%0d cyc %0d got %b exp %b", k, cyc, got_rv[k], exp_rv[k]); end
        if (exp_rv[k] != 2'b00) begin
          checks++;
          if (obs_rd !== exp_rd[k]) begin errors++; $display("FAIL starve_rdata dut%0d cyc %0d got %h exp %h", k, cyc, obs_rd, exp_rd[k]); end
        end
      end
    end
    checks++;
    if (n0_a != 13) begin errors++; $display("FAIL starve_hold16 got %0d owner grants exp 13", n0_a); end
  endtask

  task automatic test_reset_midflight;
    logic [7:0] obs_rd;
    for (int i = 0; i < 8; i++) begin
      drive((i == 0 || i == 3), (i == 2), 12'h2ab, 1'b0, (i == 2), 12'h155, 1'b0);
      if (i == 4) begin
        checks++;
        if (got_rv[0] !== 2'b00) begin errors++; $display("FAIL midflight_rvalid got %b exp 00", got_rv[0]); end
        checks++;
        if (got_ra[0] !== 12'h000 || got_st[0] !== 2'd0) begin
          errors++; $display("FAIL midflight_idle got addr %h state %0d exp 000/0", got_ra[0], got_st[0]);
        end
      end
      for (int k = 0; k < 2; k++) begin
        obs_rd = exp_rv[k][1] ? got_rd[k][15:8] : got_rd[k][7:0];
        checks++;
        if (got_gnt[k] !== exp_gnt[k]) begin errors++; $display("FAIL midflight_gnt dut%0d cyc %0d got %b exp %b", k, cyc, got_gnt[k], exp_gnt[k]); end
        checks++;
        if (got_rv[k] !== exp_rv[k]) begin errors++; $display("FAIL midflight_rvalid dut%0d cyc %0d got %b exp %b", k, cyc, got_rv[k], exp_rv[k]); end
        checks++;
        if (got_ra[k] !== exp_ra[k]) begin errors++; $display("FAIL midflight_romaddr dut%0d cyc %0d got %h exp %h", k, cyc, got_ra[k], exp_ra[k]); end
        if (exp_rv[k] != 2'b00) begin
          checks++;
          if (obs_rd !== exp_rd[k]) begin errors++; $display("FAIL midflight_rdata dut%0d cyc %0d got %h exp %h", k, cyc, obs_rd, exp_rd[k]); end
        end
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] obs_rd;
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 79) == 0),
            ($urandom_range(0, 3) != 0), 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 2; k++) begin
        obs_rd = exp_rv[k][1] ? got_rd[k][15:8] : got_rd[k][7:0];
        checks++;
        if (got_gnt[k] !== exp_gnt[k]) begin errors++; $display("FAIL random_gnt dut%0d cyc %0d got %b exp %b", k, cyc, got_gnt[k], exp_gnt[k]); end
        checks++;
        if (got_rv[k] !== exp_rv[k]) begin errors++; $display("FAIL random_rvalid dut%0d cyc %0d got %b exp %b", k, cyc, got_rv[k], exp_rv[k]); end
        checks++;
        if (got_ra[k] !== exp_ra[k]) begin errors++; $display("FAIL random_romaddr dut%0d cyc %0d got %h exp %h", k, cyc, got_ra[k], exp_ra[k]); end
        if (exp_rv[k] != 2'b00) begin
          checks++;
          if (obs_rd !== exp_rd[k]) begin errors++; $display("FAIL random_rdata dut%0d cyc %0d got %h exp %h", k, cyc, obs_rd, exp_rd[k]); end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    reset  = 1'b1;
    req0   = 1'b0; req1  = 1'b0;
    lock0  = 1'b0; lock1 = 1'b0;
    addr0  = 12'h000; addr1 = 12'h000;
    for (int k = 0; k < 2; k++) begin
      owner[k]  = -1;
      streak[k] = 0;
      last_g[k] = 1;
      mdl_ra[k] = 12'h000;
    end
    drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0);
    drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0);

    test_reset();
    test_single();
    test_contention();
    test_lock_burst();
    test_starvation();
    test_reset_midflight();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
